ps2_matrix_kbd: RTL and testbench

//  Parametrised PS/2 keyboard front end: deserialises PS/2 device frames and decodes set-2 make/break sequences, including E0/F0/E1 prefixes.

---
 rtl/kbd_pkg.sv | 139 +++++++++++++
 rtl/ps2_rx.sv | 144 ++++++++++++++
 rtl/ps2_matrix_kbd.sv | 150 +++++++++++++++
 tb/tb_ps2_matrix_kbd.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 matrix keyboard front end.
//   - set-2 scancode constants (prefixes, BAT result, boot-combo keys)
//   - receiver state encoding
//   - key_loc_t / key_pair_t matrix locations and the keymap function
//     translating {ext, code} into up to two matrix positions
//   - fkey_index: set-2 code -> F1..F12 bit index (4'hF when not an F-key)
// Used by ps2_rx and ps2_matrix_kbd. The optional receiver watchdog is
// enabled by defining PS2_WATCHDOG_EN (see ps2_rx).
package kbd_pkg;

   localparam logic [7:0] SC_E0   = 8'hE0;
   localparam logic [7:0] SC_F0   = 8'hF0;
   localparam logic [7:0] SC_E1   = 8'hE1;
   localparam logic [7:0] SC_AA   = 8'hAA;
   localparam logic [7:0] SC_CTRL = 8'h14;
   localparam logic [7:0] SC_ALT  = 8'h11;
   localparam logic [7:0] SC_DEL  = 8'h71;   // arrives with E0

   // The Pause key sends E1 followed by this many bytes.
   localparam logic [2:0] E1_SKIP = 3'd7;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PAR,
      RX_STOP
   } rx_state_t;

   typedef struct packed {
      logic       valid;
      logic [3:0] row;
      logic [3:0] col;
   } key_loc_t;

   typedef struct packed {
      key_loc_t pri;
      key_loc_t sec;
   } key_pair_t;

   // r2 < 0 means the key has no secondary position.
   function automatic key_pair_t kp(input int r1, input int c1, input int r2, input int c2);
      key_pair_t m;
      m = '0;
      m.pri.valid = 1'b1;
      m.pri.row   = 4'(r1);
      m.pri.col   = 4'(c1);
      if (r2 >= 0) begin
         m.sec.valid = 1'b1;
         m.sec.row   = 4'(r2);
         m.sec.col   = 4'(c2);
      end
      return m;
   endfunction

   // Spectrum-style 8x5 layout. Row 0 col 0 is CAPS SHIFT, row 7 col 1 is
   // SYMBOL SHIFT; cursor keys and punctuation press a shift plus a key.
   function automatic key_pair_t keymap(input logic ext, input logic [7:0] code);
      key_pair_t m;
      m = '0;
      if (!ext) begin
         case (code)
            8'h12: m = kp(0, 0, -1, 0);   // left shift  -> caps shift
            8'h59: m = kp(7, 1, -1, 0);   // right shift -> symbol shift
            8'h14: m = kp(7, 1, -1, 0);   // ctrl        -> symbol shift
            8'h1A: m = kp(0, 1, -1, 0);   // Z
            8'h22: m = kp(0, 2, -1, 0);   // X
            8'h21: m = kp(0, 3, -1, 0);   // C
            8'h2A: m = kp(0, 4, -1, 0);   // V
            8'h1C: m = kp(1, 0, -1, 0);   // A
            8'h1B: m = kp(1, 1, -1, 0);   // S
            8'h23: m = kp(1, 2, -1, 0);   // D
            8'h2B: m = kp(1, 3, -1, 0);   // F
            8'h34: m = kp(1, 4, -1, 0);   // G
            8'h15: m = kp(2, 0, -1, 0);   // Q
            8'h1D: m = kp(2, 1, -1, 0);   // W
            8'h24: m = kp(2, 2, -1, 0);   // E
            8'h2D: m = kp(2, 3, -1, 0);   // R
            8'h2C: m = kp(2, 4, -1, 0);   // T
            8'h16: m = kp(3, 0, -1, 0);   // 1
            8'h1E: m = kp(3, 1, -1, 0);   // 2
            8'h26: m = kp(3, 2, -1, 0);   // 3
            8'h25: m = kp(3, 3, -1, 0);   // 4
            8'h2E: m = kp(3, 4, -1, 0);   // 5
            8'h45: m = kp(4, 0, -1, 0);   // 0
            8'h46: m = kp(4, 1, -1, 0);   // 9
            8'h3E: m = kp(4, 2, -1, 0);   // 8
            8'h3D: m = kp(4, 3, -1, 0);   // 7
            8'h36: m = kp(4, 4, -1, 0);   // 6
            8'h4D: m = kp(5, 0, -1, 0);   // P
            8'h44: m = kp(5, 1, -1, 0);   // O
            8'h43: m = kp(5, 2, -1, 0);   // I
            8'h3C: m = kp(5, 3, -1, 0);   // U
            8'h35: m = kp(5, 4, -1, 0);   // Y
            8'h5A: m = kp(6, 0, -1, 0);   // Enter
            8'h4B: m = kp(6, 1, -1, 0);   // L
            8'h42: m = kp(6, 2, -1, 0);   // K
            8'h3B: m = kp(6, 3, -1, 0);   // J
            8'h33: m = kp(6, 4, -1, 0);   // H
            8'h29: m = kp(7, 0, -1, 0);   // Space
            8'h3A: m = kp(7, 2, -1, 0);   // M
            8'h31: m = kp(7, 3, -1, 0);   // N
            8'h32: m = kp(7, 4, -1, 0);   // B
            8'h66: m = kp(0, 0,  4, 0);   // Backspace = caps + 0
            8'h41: m = kp(7, 1,  7, 3);   // ,         = sym + N
            8'h49: m = kp(7, 1,  7, 2);   // .         = sym + M
            8'h4E: m = kp(7, 1,  6, 3);   // -         = sym + J
            default: m = '0;
         endcase
      end else begin
         case (code)
            8'h6B: m = kp(0, 0, 3, 4);    // left  = caps + 5
            8'h72: m = kp(0, 0, 4, 4);    // down  = caps + 6
            8'h75: m = kp(0, 0, 4, 3);    // up    = caps + 7
            8'h74: m = kp(0, 0, 4, 2);    // right = caps + 8
            default: m = '0;
         endcase
      end
      return m;
   endfunction

   function automatic logic [3:0] fkey_index(input logic [7:0] code);
      case (code)
         8'h05:   return 4'd0;
         8'h06:   return 4'd1;
         8'h04:   return 4'd2;
         8'h0C:   return 4'd3;
         8'h03:   return 4'd4;
         8'h0B:   return 4'd5;
         8'h83:   return 4'd6;
         8'h0A:   return 4'd7;
         8'h01:   return 4'd8;
         8'h09:   return 4'd9;
         8'h78:   return 4'd10;
         8'h07:   return 4'd11;
         default: return 4'hF;
      endcase
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver.
// Ports:
//   i_clk, i_rst    system clock, asynchronous active-high reset
//   i_ce            clock enable; nothing advances while low
//   i_ps2           [1]=data, [0]=clock, raw from the connector
//   o_byte          last received byte (valid while o_byte_valid is high)
//   o_byte_valid    one-tick pulse: frame with good parity and stop bit
//   o_frame_err     one-tick pulse: parity/stop error or watchdog expiry
//   o_timeout       one-tick pulse: watchdog expiry only
// The PS/2 clock is glitch-filtered by a FILTER-deep shift register; the
// filtered clock only changes once the register is all ones or all zeros.
// Defining PS2_WATCHDOG_EN adds a frame watchdog of TIMEOUT ce ticks.
module ps2_rx
   import kbd_pkg::*;
#(
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 2000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ce,
   input  logic [1:0] i_ps2,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err,
   output logic       o_timeout
);

   logic [FILTER-1:0] r_filt;
   logic              r_fclk;
   logic              r_fall;
   logic              r_data;
   rx_state_t         r_state;
   rx_state_t         w_next;
   logic [7:0]        r_shift;
   logic [2:0]        r_cnt;
   logic              r_par_ok;
   logic              r_byte_valid;
   logic              r_frame_err;
   logic              r_timeout;
   logic              w_valid;
   logic              w_err;
   logic              w_timeout;

   // Filter / edge detect: the shift register also synchronises ps2[0].
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_filt <= '1;
         r_fclk <= 1'b1;
         r_fall <= 1'b0;
         r_data <= 1'b1;
      end else if (i_ce) begin
         r_filt <= {r_filt[FILTER-2:0], i_ps2[0]};
         r_data <= i_ps2[1];
         r_fall <= 1'b0;
         if (&r_filt) begin
            r_fclk <= 1'b1;
         end else if (~|r_filt) begin
            r_fclk <= 1'b0;
            r_fall <= r_fclk;
         end
      end
   end

`ifdef PS2_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] r_wd;

   // A fall in the same tick as expiry wins: the frame is still alive.
   assign w_timeout = (r_state != RX_IDLE) && !r_fall && (r_wd == WD_W'(TIMEOUT));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wd <= '0;
      end else if (i_ce) begin
         if (r_fall || (r_state == RX_IDLE) || w_timeout) r_wd <= '0;
         else                                              r_wd <= r_wd + 1'b1;
      end
   end
`else
   // No watchdog: a partial frame waits for more edges (0 for any legal TIMEOUT).
   assign w_timeout = (TIMEOUT < 0);
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= RX_IDLE;
      else if (i_ce) r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_valid = 1'b0;
      w_err   = 1'b0;
      if (w_timeout) begin
         w_next = RX_IDLE;
         w_err  = 1'b1;
      end else if (r_fall) begin
         case (r_state)
            RX_IDLE: if (!r_data) w_next = RX_DATA;
            RX_DATA: if (r_cnt == 3'd7) w_next = RX_PAR;
            RX_PAR:  w_next = RX_STOP;
            RX_STOP: begin
               w_next = RX_IDLE;
               if (r_data && r_par_ok) w_valid = 1'b1;
               else                    w_err   = 1'b1;
            end
            default: w_next = RX_IDLE;
         endcase
      end
   end

   // Shift / parity datapath and registered output pulses.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shift      <= '0;
         r_cnt        <= '0;
         r_par_ok     <= 1'b0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         r_timeout    <= 1'b0;
      end else if (i_ce) begin
         r_byte_valid <= w_valid;
         r_frame_err  <= w_err;
         r_timeout    <= w_timeout;
         if (r_fall && !w_timeout) begin
            case (r_state)
               RX_IDLE: r_cnt <= '0;
               RX_DATA: begin
                  r_shift <= {r_data, r_shift[7:1]};
                  r_cnt   <= r_cnt + 3'd1;
               end
               RX_PAR:  r_par_ok <= ^{r_shift, r_data};   // odd parity
               default: ;
            endcase
         end
      end
   end

   assign o_byte       = r_shift;
   assign o_byte_valid = r_byte_valid;
   assign o_frame_err  = r_frame_err;
   assign o_timeout    = r_timeout;

endmodule

// File: rtl/ps2_matrix_kbd.sv
// PS/2 keyboard front end with key matrix output.
// Ports:
//   clock, reset  system clock, asynchronous active-high reset
//   ce            clock enable for all sequential logic
//   ps2           [1]=PS/2 data, [0]=PS/2 clock (raw)
//   a             ROWS half-row selects, active-low
//   q             COLS column read, active-low, combinational from a
//   fkey_n        F1..F12 held, active-low, bit0=F1
//   boot_n        low while F11 held or Ctrl+Alt+Del held
//   code_stb      one-tick pulse with code/code_ext/code_rel
//   code          scancode byte with prefixes stripped
//   code_ext      event carried an E0 prefix
//   code_rel      event carried an F0 prefix (break)
//   frame_err     one-tick pulse on a bad frame or watchdog expiry
// Define PS2_WATCHDOG_EN to enable the receiver frame watchdog.
module ps2_matrix_kbd
   import kbd_pkg::*;
#(
   parameter int ROWS    = 8,
   parameter int COLS    = 5,
   parameter int FILTER  = 8,
   parameter int TIMEOUT = 2000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            ce,
   input  logic [1:0]      ps2,
   input  logic [ROWS-1:0] a,
   output logic [COLS-1:0] q,
   output logic [11:0]     fkey_n,
   output logic            boot_n,
   output logic            code_stb,
   output logic [7:0]      code,
   output logic            code_ext,
   output logic            code_rel,
   output logic            frame_err
);

   logic [7:0]                 w_byte;
   logic                       w_byte_valid;
   logic                       w_timeout;
   key_pair_t                  w_map;
   logic [3:0]                 w_fidx;

   logic                       r_ext;
   logic                       r_rel;
   logic [2:0]                 r_skip;
   logic                       r_code_stb;
   logic [7:0]                 r_code;
   logic                       r_code_ext;
   logic                       r_code_rel;
   logic [ROWS-1:0][COLS-1:0]  r_key;
   logic [11:0]                r_fkey_n;
   logic                       r_ctrl;
   logic                       r_alt;
   logic                       r_del;

   ps2_rx #(
      .FILTER  (FILTER),
      .TIMEOUT (TIMEOUT)
   ) u_rx (
      .i_clk        (clock),
      .i_rst        (reset),
      .i_ce         (ce),
      .i_ps2        (ps2),
      .o_byte       (w_byte),
      .o_byte_valid (w_byte_valid),
      .o_frame_err  (frame_err),
      .o_timeout    (w_timeout)
   );

   // Lookup uses the prefix state in force when the final byte arrives.
   assign w_map  = keymap(r_ext, w_byte);
   assign w_fidx = fkey_index(w_byte);

   // Prefix decoder, matrix and F-key / boot-combo state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ext      <= 1'b0;
         r_rel      <= 1'b0;
         r_skip     <= '0;
         r_code_stb <= 1'b0;
         r_code     <= '0;
         r_code_ext <= 1'b0;
         r_code_rel <= 1'b0;
         r_key      <= '1;
         r_fkey_n   <= '1;
         r_ctrl     <= 1'b0;
         r_alt      <= 1'b0;
         r_del      <= 1'b0;
      end else if (ce) begin
         r_code_stb <= 1'b0;
         if (w_timeout) begin
            r_ext  <= 1'b0;
            r_rel  <= 1'b0;
            r_skip <= '0;
         end else if (w_byte_valid) begin
            if (r_skip != '0) begin
               r_skip <= r_skip - 3'd1;
            end else if (w_byte == SC_E0) begin
               r_ext <= 1'b1;
            end else if (w_byte == SC_F0) begin
               r_rel <= 1'b1;
            end else if (w_byte == SC_E1) begin
               r_skip <= E1_SKIP;
            end else if (w_byte == SC_AA) begin
               r_key    <= '1;
               r_fkey_n <= '1;
            end else begin
               r_code_stb <= 1'b1;
               r_code     <= w_byte;
               r_code_ext <= r_ext;
               r_code_rel <= r_rel;
               r_ext      <= 1'b0;
               r_rel      <= 1'b0;
               // Secondary write comes last so it wins on a shared cell.
               for (int r = 0; r < ROWS; r++) begin
                  for (int c = 0; c < COLS; c++) begin
                     if (w_map.pri.valid && w_map.pri.row == 4'(r) && w_map.pri.col == 4'(c))
                        r_key[r][c] <= r_rel;
                     if (w_map.sec.valid && w_map.sec.row == 4'(r) && w_map.sec.col == 4'(c))
                        r_key[r][c] <= r_rel;
                  end
               end
               if (!r_ext && w_fidx != 4'hF) r_fkey_n[w_fidx] <= r_rel;
               if (!r_ext && w_byte == SC_CTRL) r_ctrl <= ~r_rel;
               if (!r_ext && w_byte == SC_ALT)  r_alt  <= ~r_rel;
               if ( r_ext && w_byte == SC_DEL)  r_del  <= ~r_rel;
            end
         end
      end
   end

   always_comb begin
      q = '1;
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            q[c] = q[c] & (a[r] | r_key[r][c]);
         end
      end
   end

   assign fkey_n   = r_fkey_n;
   assign boot_n   = r_fkey_n[10] & ~(r_ctrl & r_alt & r_del);
   assign code_stb = r_code_stb;
   assign code     = r_code;
   assign code_ext = r_code_ext;
   assign code_rel = r_code_rel;

endmodule

// File: tb/tb_ps2_matrix_kbd.sv
`timescale 1ns/1ps
module tb_ps2_matrix_kbd;

   localparam int TIMEOUT = 2000;

   logic        clock = 1'b0;
   logic        reset;
   logic        ce;
   logic [1:0]  ps2;
   logic [7:0]  a;
   logic [4:0]  q;
   logic [11:0] fkey_n;
   logic        boot_n;
   logic        code_stb;
   logic [7:0]  code;
   logic        code_ext;
   logic        code_rel;
   logic        frame_err;

   ps2_matrix_kbd #(.ROWS(8), .COLS(5), .FILTER(8), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .ce(ce), .ps2(ps2), .a(a), .q(q),
      .fkey_n(fkey_n), .boot_n(boot_n), .code_stb(code_stb), .code(code),
      .code_ext(code_ext), .code_rel(code_rel), .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   int ferr_seen = 0;
   int ferr_exp  = 0;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       rel;
   } ev_t;
   ev_t exp_q[$];

   // Reference key table: {ext, code, row1, col1, row2, col2}, F = none.
   logic [27:0] km[$] = {
      28'h0_12_00FF, 28'h0_59_71FF, 28'h0_14_71FF,
      28'h0_1A_01FF, 28'h0_22_02FF, 28'h0_21_03FF, 28'h0_2A_04FF,
      28'h0_1C_10FF, 28'h0_1B_11FF, 28'h0_23_12FF, 28'h0_2B_13FF, 28'h0_34_14FF,
      28'h0_15_20FF, 28'h0_1D_21FF, 28'h0_24_22FF, 28'h0_2D_23FF, 28'h0_2C_24FF,
      28'h0_16_30FF, 28'h0_1E_31FF, 28'h0_26_32FF, 28'h0_25_33FF, 28'h0_2E_34FF,
      28'h0_45_40FF, 28'h0_46_41FF, 28'h0_3E_42FF, 28'h0_3D_43FF, 28'h0_36_44FF,
      28'h0_4D_50FF, 28'h0_44_51FF, 28'h0_43_52FF, 28'h0_3C_53FF, 28'h0_35_54FF,
      28'h0_5A_60FF, 28'h0_4B_61FF, 28'h0_42_62FF, 28'h0_3B_63FF, 28'h0_33_64FF,
      28'h0_29_70FF, 28'h0_3A_72FF, 28'h0_31_73FF, 28'h0_32_74FF,
      28'h0_66_0040, 28'h0_41_7173, 28'h0_49_7172, 28'h0_4E_7163,
      28'h1_6B_0034, 28'h1_72_0044, 28'h1_75_0043, 28'h1_74_0042
   };
   logic [7:0] FK[12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B,
                          8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
   logic [7:0] POOL[28] = '{8'h1C, 8'h1B, 8'h23, 8'h12, 8'h59, 8'h14, 8'h11,
                            8'h71, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h66, 8'h41,
                            8'h49, 8'h4E, 8'h29, 8'h5A, 8'h45, 8'h16, 8'h05,
                            8'h78, 8'h07, 8'h83, 8'h76, 8'h0E, 8'h3A, 8'h32};

   logic [4:0]  m_key[8];
   logic [11:0] m_fkey;
   logic        m_ctrl, m_alt, m_del;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic exp_boot();
      return m_fkey[10] & ~(m_ctrl & m_alt & m_del);
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 8; r++) m_key[r] = 5'h1F;
      m_fkey = 12'hFFF;
      m_ctrl = 1'b0;
      m_alt  = 1'b0;
      m_del  = 1'b0;
   endtask

   // One complete key event as seen by the host.
   task automatic model_event(input logic ext, input logic rel, input logic [7:0] cd);
      ev_t e;
      e.code = cd;
      e.ext  = ext;
      e.rel  = rel;
      exp_q.push_back(e);
      foreach (km[i]) begin
         if (km[i][27:24] == {3'b000, ext} && km[i][23:16] == cd) begin
            m_key[km[i][15:12]][km[i][11:8]] = rel;
            if (km[i][7:4] != 4'hF) m_key[km[i][7:4]][km[i][3:0]] = rel;
         end
      end
      if (!ext) begin
         for (int i = 0; i < 12; i++) if (FK[i] == cd) m_fkey[i] = rel;
         if (cd == 8'h14) m_ctrl = ~rel;
         if (cd == 8'h11) m_alt  = ~rel;
      end else if (cd == 8'h71) begin
         m_del = ~rel;
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clock); ps2[1] = b;
      repeat (6) @(negedge clock);
      ps2[0] = 1'b0;
      repeat (10) @(negedge clock);
      ps2[0] = 1'b1;
      repeat (10) @(negedge clock);
      if ($urandom_range(0, 3) == 0) begin
         // short glitch, well below the filter length
         ps2[0] = 1'b0;
         repeat (3) @(negedge clock);
         ps2[0] = 1'b1;
         repeat (10) @(negedge clock);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad);
      send_bit(1'b1);
      repeat (20) @(negedge clock);
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
      chk({nm, "_pending_events"}, exp_q.size(), 0);
   endtask

   task automatic send_key(input logic ext, input logic rel, input logic [7:0] cd);
      if (ext) send_frame(8'hE0, 1'b0);
      if (rel) send_frame(8'hF0, 1'b0);
      model_event(ext, rel, cd);
      send_frame(cd, 1'b0);
      wait_drain($sformatf("key_%0h", cd));
   endtask

   task automatic check_state(input string tag);
      logic [4:0] all_rows;
      all_rows = 5'h1F;
      for (int r = 0; r < 8; r++) begin
         @(negedge clock); a = ~(8'h01 << r); #1;
         chk($sformatf("%s_q_row%0d", tag, r), q, m_key[r]);
         all_rows = all_rows & m_key[r];
      end
      @(negedge clock); a = 8'h00; #1;
      chk({tag, "_q_allrows"}, q, all_rows);
      a = 8'hFF; #1;
      chk({tag, "_q_norow"}, q, 5'h1F);
      chk({tag, "_fkey_n"}, fkey_n, m_fkey);
      chk({tag, "_boot_n"}, boot_n, exp_boot());
   endtask

   // Scoreboard monitor: every strobe must match the oldest expected event.
   always @(negedge clock) begin
      if (code_stb === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_code_stb: got code %0h ext %0b rel %0b, required no event",
                     code, code_ext, code_rel);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("code", code, e.code);
            chk("code_ext", code_ext, e.ext);
            chk("code_rel", code_rel, e.rel);
         end
      end
      if (frame_err === 1'b1) ferr_seen++;
   end

   initial begin
      #5ms;
      n_errors++;
      $display("FAIL global_time_limit: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "time limit");
   end

   initial begin
      logic [7:0] b;
      reset = 1'b1;
      ce    = 1'b1;
      ps2   = 2'b11;
      a     = 8'hFF;
      model_reset();
      repeat (3) @(negedge clock);
      a = 8'h00; #1;
      chk("rst_q", q, 5'h1F);
      chk("rst_fkey_n", fkey_n, 12'hFFF);
      chk("rst_boot_n", boot_n, 1'b1);
      chk("rst_code_stb", code_stb, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_code", code, 8'h00);
      chk("rst_code_ext", code_ext, 1'b0);
      chk("rst_code_rel", code_rel, 1'b0);
      a = 8'hFF;
      @(negedge clock); reset = 1'b0;
      repeat (5) @(negedge clock);

      // make / break A
      send_key(1'b0, 1'b0, 8'h1C);
      @(negedge clock); a = 8'hFD; #1;
      chk("a_make_q", q, 5'b11110);
      check_state("a_make");
      send_key(1'b0, 1'b1, 8'h1C);
      @(negedge clock); a = 8'hFD; #1;
      chk("a_break_q", q, 5'b11111);

      // bad parity
      send_key(1'b0, 1'b0, 8'h1B);
      send_frame(8'h1C, 1'b1);
      ferr_exp++;
      chk("bad_parity_frame_err", ferr_seen, ferr_exp);
      check_state("bad_parity");
      send_key(1'b0, 1'b1, 8'h1B);

      // extended cursor up
      send_key(1'b1, 1'b0, 8'h75);
      check_state("up_make");
      send_key(1'b1, 1'b1, 8'h75);
      check_state("up_break");

      // boot combinations
      send_key(1'b0, 1'b0, 8'h14);
      send_key(1'b0, 1'b0, 8'h11);
      send_key(1'b1, 1'b0, 8'h71);
      chk("boot_cad_held", boot_n, 1'b0);
      send_key(1'b0, 1'b1, 8'h11);
      chk("boot_alt_released", boot_n, 1'b1);
      send_key(1'b0, 1'b1, 8'h14);
      send_key(1'b1, 1'b1, 8'h71);
      send_key(1'b0, 1'b0, 8'h78);
      chk("boot_f11", boot_n, 1'b0);
      chk("fkey_f11", fkey_n[10], 1'b0);
      check_state("f11");
      send_key(1'b0, 1'b1, 8'h78);

      // hot-plug clear and Pause swallowing
      send_key(1'b0, 1'b0, 8'h1C);
      send_key(1'b0, 1'b0, 8'h05);
      send_frame(8'hAA, 1'b0);
      for (int r = 0; r < 8; r++) m_key[r] = 5'h1F;
      m_fkey = 12'hFFF;
      check_state("bat_clear");
      send_frame(8'hE1, 1'b0);
      send_frame(8'h14, 1'b0);
      send_frame(8'h77, 1'b0);
      send_frame(8'hE1, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h14, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h77, 1'b0);
      check_state("pause");
      send_key(1'b0, 1'b0, 8'h23);
      check_state("after_pause");

      // reset in the middle of a frame
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      @(negedge clock); reset = 1'b1;
      repeat (2) @(negedge clock); reset = 1'b0;
      model_reset();
      check_state("mid_reset");
      send_key(1'b0, 1'b0, 8'h2B);
      check_state("after_mid_reset");

      // randomized key events
      for (int n = 0; n < 30; n++) begin
         b = POOL[$urandom_range(0, 27)];
         send_key(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), b);
         check_state($sformatf("rnd%0d", n));
      end

      // stalled frame
      b = 8'h2D;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(b[i]);
      repeat (TIMEOUT + 50) @(negedge clock);
`ifdef PS2_WATCHDOG_EN
      ferr_exp++;
      chk("watchdog_frame_err", ferr_seen, ferr_exp);
      model_event(1'b0, 1'b0, b);
      send_frame(b, 1'b0);
      wait_drain("after_watchdog");
`else
      chk("stall_no_frame_err", ferr_seen, ferr_exp);
      model_event(1'b0, 1'b0, b);
      for (int i = 4; i < 8; i++) send_bit(b[i]);
      send_bit(~^b);
      send_bit(1'b1);
      repeat (20) @(negedge clock);
      wait_drain("resumed_frame");
`endif
      check_state("stall");

      chk("final_frame_err_count", ferr_seen, ferr_exp);
      chk("final_pending_events", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
